// File: rtl/icache_axi_rd_bridge.sv
// Single-beat AXI4 read master for the I-cache refill port: one 64-bit AR, one R beat, one-cycle response.
// Optional R-wait watchdog with a drain state is enabled by defining ICACHE_AXI_TIMEOUT_EN.
module icache_axi_rd_bridge #(
    parameter logic [3:0] AXI_ID      = 4'd0,
    parameter int         TIMEOUT_CYC = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_ena,
    input  logic [63:0] req_addr,
    output logic [63:0] rsp_data,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    output logic [3:0]  arid,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    input  logic        rvalid,
    output logic        rready,
    input  logic [63:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast
);

    typedef enum logic [2:0] {
        IDLE,
        AR,
        R,
        RSP
`ifdef ICACHE_AXI_TIMEOUT_EN
        , DRAIN
`endif
    } state_t;

    state_t state, state_nxt;

    assign arid    = AXI_ID;
    assign arlen   = 8'd0;
    assign arsize  = 3'b011;
    assign arburst = 2'b01;

    // Address bits above 31, the doubleword offset and RLAST carry no information here.
    logic unused_bits;

`ifdef ICACHE_AXI_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;
    logic          timed_out;
    logic          expire;

    assign unused_bits = ^{req_addr[63:32], req_addr[2:0], rlast};
    // A beat arriving in the expiry cycle takes priority over the watchdog.
    assign expire = (state == R) && !rvalid && (cnt == LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            timed_out <= 1'b0;
        end else begin
            if (state == AR && arready)
                cnt <= '0;
            else if (state == R && !rvalid)
                cnt <= cnt + 1'b1;
            if (state == R)
                timed_out <= expire;
        end
    end
`else
    assign unused_bits = ^{req_addr[63:32], req_addr[2:0], rlast, (TIMEOUT_CYC > 0)};
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        arvalid   = 1'b0;
        rready    = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (req_ena)
                    state_nxt = AR;
            end
            AR: begin
                arvalid = 1'b1;
                if (arready)
                    state_nxt = R;
            end
            R: begin
                rready = 1'b1;
                if (rvalid)
                    state_nxt = RSP;
`ifdef ICACHE_AXI_TIMEOUT_EN
                else if (expire)
                    state_nxt = RSP;
`endif
            end
            RSP: begin
                rsp_valid = 1'b1;
`ifdef ICACHE_AXI_TIMEOUT_EN
                state_nxt = timed_out ? DRAIN : IDLE;
`else
                state_nxt = IDLE;
`endif
            end
`ifdef ICACHE_AXI_TIMEOUT_EN
            // The abandoned beat must still be consumed before a new AR may go out.
            DRAIN: begin
                rready = 1'b1;
                if (rvalid)
                    state_nxt = IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            araddr   <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            if (state == IDLE && req_ena)
                araddr <= {req_addr[31:3], 3'b000};
            if (state == R && rvalid) begin
                rsp_data <= rdata;
                rsp_err  <= (rresp != 2'b00);
            end
`ifdef ICACHE_AXI_TIMEOUT_EN
            else if (expire) begin
                rsp_data <= '0;
                rsp_err  <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Randomized transaction-level bench for icache_axi_rd_bridge; the watchdog scenario
// runs only when ICACHE_AXI_TIMEOUT_EN is defined (TIMEOUT_CYC overridden to 8).
module tb_icache_axi_rd_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_ena;
    logic [63:0] req_addr;
    logic [63:0] rsp_data;
    logic        rsp_valid;
    logic        rsp_err;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid;
    logic        rready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    icache_axi_rd_bridge #(.AXI_ID(4'd5), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst), .req_ena(req_ena), .req_addr(req_addr),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_arvalid"}, arvalid, 0);
        check({tag, "_rready"}, rready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_err"}, rsp_err, 0);
        check({tag, "_rsp_data"}, rsp_data, 0);
        check({tag, "_araddr"}, araddr, 0);
    endtask

    // One refill seen from the cache and from an AXI slave. Expectations come straight from
    // the request address and the beat the slave returns. Entered and left in the idle state.
    task automatic do_txn(input logic [63:0] addr, input int ar_dly, input int r_dly,
                          input logic [63:0] data, input logic [1:0] resp,
                          input bit drop, input bit early_r, input bit keep);
        logic [31:0] exp_addr;
        exp_addr = {addr[31:3], 3'b000};
        req_ena  = 1'b1;
        req_addr = addr;
        tick();
        for (int i = 0; i <= ar_dly; i++) begin
            check("ar_valid", arvalid, 1);
            check("ar_addr", araddr, exp_addr);
            check("ar_rready", rready, 0);
            check("ar_rsp_valid", rsp_valid, 0);
            check("ar_fields", {arid, arlen, arsize, arburst}, {4'd5, 8'd0, 3'b011, 2'b01});
            arready  = (i == ar_dly);
            req_addr = rnd64();
            if (drop) req_ena = 1'b0;
            if (early_r) begin
                rvalid = 1'b1;
                rdata  = data;
                rresp  = resp;
            end
            tick();
        end
        arready = 1'b0;
        for (int i = 0; i <= r_dly; i++) begin
            check("r_rready", rready, 1);
            check("r_arvalid", arvalid, 0);
            check("r_rsp_valid", rsp_valid, 0);
            rvalid = (i == r_dly);
            rdata  = (i == r_dly) ? data : rnd64();
            rresp  = (i == r_dly) ? resp : 2'($urandom);
            rlast  = rvalid;
            tick();
        end
        rvalid = 1'b0;
        rdata  = rnd64();
        check("rsp_valid", rsp_valid, 1);
        check("rsp_data", rsp_data, data);
        check("rsp_err", rsp_err, resp != 2'b00);
        check("rsp_rready", rready, 0);
        check("rsp_arvalid", arvalid, 0);
        req_ena  = keep;
        req_addr = rnd64();
        tick();
        check("post_rsp_valid", rsp_valid, 0);
        check("post_no_ar", arvalid, 0);
        check("hold_data", rsp_data, data);
        check("hold_err", rsp_err, resp != 2'b00);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [63:0] a;
        int gap;
        rst = 1'b1; req_ena = 1'b0; req_addr = '0; arready = 1'b0;
        rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();
        check("idle_no_ar", arvalid, 0);

        // Minimum-latency refill with the R beat already waiting.
        do_txn(64'h8000_0014, 0, 0, 64'h1122_3344_5566_7788, 2'b00, 0, 1, 0);
        // AR back-pressure for three cycles.
        do_txn(64'h8000_0100, 3, 1, 64'hCAFE_F00D_0000_0001, 2'b00, 0, 0, 0);
        // Slave error response.
        do_txn(64'h8000_0200, 0, 2, 64'h0000_0000_0000_DEAD, 2'b10, 0, 0, 0);
        // req_ena dropped while the AR is pending.
        do_txn(64'h8000_0300, 2, 0, 64'h0123_4567_89AB_CDEF, 2'b00, 1, 0, 0);
        // Back-to-back requests, req_ena held through the response cycle.
        do_txn(64'h8000_0000, 0, 0, 64'hAAAA_0000_0000_0001, 2'b00, 0, 0, 1);
        do_txn(64'h8000_0008, 0, 0, 64'hBBBB_0000_0000_0002, 2'b00, 0, 0, 0);

        // Reset while waiting for the R beat, then a fresh request.
        req_ena = 1'b1; req_addr = 64'h8000_0400;
        tick();
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check("pre_rst_rready", rready, 1);
        rst = 1'b1;
        tick();
        check_reset_outputs("mid_reset");
        rst = 1'b0; req_ena = 1'b0;
        tick();
        check("after_rst_no_ar", arvalid, 0);
        do_txn(64'h8000_0408, 1, 1, 64'h5555_6666_7777_8888, 2'b01, 0, 0, 0);

`ifdef ICACHE_AXI_TIMEOUT_EN
        // Silent slave: watchdog expiry after 8 R cycles, then the late beat is drained.
        req_ena = 1'b1; req_addr = 64'h8000_0500;
        tick();
        arready = 1'b1;
        tick();
        arready = 1'b0; req_ena = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("to_wait_rready", rready, 1);
            check("to_wait_no_rsp", rsp_valid, 0);
            tick();
        end
        check("to_rsp_valid", rsp_valid, 1);
        check("to_rsp_err", rsp_err, 1);
        check("to_rsp_data", rsp_data, 0);
        req_ena = 1'b1; req_addr = 64'h9000_0040;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("drain_rready", rready, 1);
            check("drain_blocks_ar", arvalid, 0);
            check("drain_no_rsp", rsp_valid, 0);
            tick();
        end
        rvalid = 1'b1; rdata = 64'hFFFF_EEEE_DDDD_CCCC; rresp = 2'b00;
        tick();
        rvalid = 1'b0;
        check("drained_idle_no_ar", arvalid, 0);
        check("drained_rready", rready, 0);
        check("drained_discard", rsp_data, 0);
        do_txn(64'h9000_0040, 0, 0, 64'h1357_9BDF_0246_8ACE, 2'b00, 0, 0, 0);
        // Beat arriving exactly in the expiry cycle is a normal response.
        do_txn(64'h9000_0080, 0, 7, 64'h2468_ACE0_1357_9BDF, 2'b00, 0, 0, 0);
`endif

        // Randomized refills with random back-pressure, responses and idle gaps.
        for (int t = 0; t < 60; t++) begin
            a   = rnd64();
            gap = $urandom_range(0, 2);
            do_txn(a, $urandom_range(0, 4), $urandom_range(0, 5), rnd64(), 2'($urandom),
                   ($urandom_range(0, 3) == 0), 0, (gap == 0));
            if (gap != 0) begin
                for (int g = 0; g < gap; g++) begin
                    req_addr = rnd64();
                    tick();
                    check("gap_no_ar", arvalid, 0);
                    check("gap_no_rsp", rsp_valid, 0);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
